stream_mux2: RTL and testbench
==============================

# stream_mux2

Two-to-one streaming multiplexer: the transmit-side counterpart of the `demux` gate, merging two valid/ready input channels A and B into one output channel. Each output beat carries a `out_sel` tag (0 = A, 1 = B), so a downstream `demux` can route it back to the matching destination. Arbitration is packet-granular: once a source wins, it keeps the output until it sends a beat with `last` set. The output is a single registered stage, so the block also breaks the timing path between producers and consumer.

## Interface
- `WIDTH`, default 8: data width of each channel, in bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_data`  in  WIDTH  channel A payload.
- `a_valid`  in  1  channel A beat available.
- `a_last`  in  1  channel A beat ends a packet.
- `a_ready`  out  1  channel A beat accepted this cycle when `a_valid && a_ready`.
- `b_data`, `b_valid`, `b_last`, `b_ready`: same as A, for channel B.
- `out_data`  out  WIDTH  registered payload.
- `out_sel`  out  1  source of the current beat: 0 = A, 1 = B.
- `out_last`  out  1  registered copy of the source `last`.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accepts the beat when `out_valid && out_ready`.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `out_last`=0, state=IDLE, priority pointer=A.
- Output slot is free when `!out_valid || out_ready`.
- `a_ready`/`b_ready` are combinational. Only the granted channel sees ready=1, and only while the slot is free. The non-granted ready is 0.
- State machine:
  - IDLE: grant goes to the eligible requester; if both request, grant goes to the pointer.
  - LOCKED_A / LOCKED_B: grant is fixed to the locked source, and the other source is ignored even when valid.
- Transitions:
  - IDLE → LOCKED_x when a beat from x is accepted with last=0.
  - IDLE → IDLE when the accepted beat has last=1 (single-beat packet).
  - LOCKED_x → IDLE when a beat from x is accepted with last=1.
  - LOCKED_x holds otherwise, including when x deasserts valid mid-packet. No timeout exists.
- Pointer update: on every accepted last=1 beat, the pointer moves to the other source (round-robin per packet).
- On an accepted beat, the output register loads data, sel and last, and `out_valid` goes to 1.
- If the slot is consumed with no new beat, `out_valid` goes to 0 and data, sel and last hold their values.
- Simultaneous consume and load in the same cycle is a pass-through at full rate: no bubble, and `out_valid` stays 1.
- Input requirement: a source holds `data` and `last` stable while valid && !ready. The block does not check this.
- Reset mid-packet drops the in-flight output beat and returns to IDLE. Sources must restart their packets.

## Timing
- Latency: 1 cycle from the input handshake to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Stall: while `out_valid && !out_ready`, both input readies are 0 and all outputs hold.
- Ready has a combinational path from `out_ready`, `*_valid` and state. There is no combinational path from any `*_data` to any output.
- Switching source between packets costs no idle cycle: a last beat from A can be followed by B's first beat in the next cycle.

## Configuration
- `STREAM_MUX2_RR_EN` defined: round-robin pointer as described above.
- Not defined: fixed priority, where A always wins in IDLE when both request. The pointer register is removed. Packet locking is unchanged.

## Test plan
- Reset: assert `rst` for 2 cycles with both inputs valid → all outputs 0, both readies 0 during reset, and `out_valid`=1 one cycle after release.
- Single source: A sends 0x11, 0x22, 0x33 (last on 0x33), `out_ready`=1 → out shows 0x11, 0x22, 0x33 on consecutive cycles, sel=0, last only on 0x33.
- Contention, RR build: A and B both send 2-beat packets (A: 0xA0, 0xA1; B: 0xB0, 0xB1) continuously → output order A0, A1, B0, B1, A0, …, with no interleaving inside a packet.
- Lock hold: A sends 0x01 (last=0), then deasserts valid for 3 cycles while B is valid → `b_ready` stays 0, and A's 0x02 (last=1) is then followed by B's beat.
- Backpressure: `out_ready`=0 for 4 cycles mid-stream → `out_data` stays stable, input readies are 0, and no beat is lost or duplicated when `out_ready` returns to 1.
- Fixed priority (macro undefined): both sources send single-beat packets continuously → only A is granted while `a_valid`=1.

Source files
------------

// File: rtl/stream_mux2_if.sv
// rtl/stream_mux2_if.sv - stream bundle for the two-to-one stream multiplexer
// Purpose: groups the two input channels (A, B) and the merged output channel
//          into one bundle so the mux and its environment share one port.
// Signals:
//   a_data/a_valid/a_last/a_ready  channel A beat and handshake
//   b_data/b_valid/b_last/b_ready  channel B beat and handshake
//   out_data/out_sel/out_last      registered output beat, sel 0 = A, 1 = B
//   out_valid/out_ready            output handshake
// Modports:
//   slave   the multiplexer side (consumes A/B, produces out)
//   master  the environment side (produces A/B, consumes out)
interface stream_mux2_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_last;
  logic             a_ready;

  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_last;
  logic             b_ready;

  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  a_data, a_valid, a_last,
    output a_ready,
    input  b_data, b_valid, b_last,
    output b_ready,
    output out_data, out_sel, out_last, out_valid,
    input  out_ready
  );

  modport master (
    output a_data, a_valid, a_last,
    input  a_ready,
    output b_data, b_valid, b_last,
    input  b_ready,
    input  out_data, out_sel, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/stream_mux2.sv
// rtl/stream_mux2.sv - two-to-one packet-granular stream multiplexer
// Purpose: merges channels A and B into one registered output channel. A
//          source that wins arbitration keeps the output until it sends a
//          beat with last set. Each output beat is tagged with its source.
// Ports:
//   i_clk  clock, all state updates on the rising edge
//   i_rst  synchronous, active-high reset
//   bus    stream_mux2_if.slave
//            in : a_data/a_valid/a_last, b_data/b_valid/b_last, out_ready
//            out: a_ready, b_ready (combinational),
//                 out_data/out_sel/out_last/out_valid (registered)
// Parameters:
//   WIDTH  payload width of each channel, in bits
// Configuration:
//   STREAM_MUX2_RR_EN defined   : round-robin pointer, flipped on every
//                                 accepted last beat.
//   STREAM_MUX2_RR_EN undefined : fixed priority, A wins contention in IDLE.
module stream_mux2 #(
  parameter int WIDTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  stream_mux2_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCKED_A = 2'd1,
    ST_LOCKED_B = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_data;
  logic             r_sel;
  logic             r_last;
  logic             r_valid;

  logic             w_slot_free;
  logic             w_prefer_b;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_ready_a;
  logic             w_ready_b;
  logic             w_acc_a;
  logic             w_acc_b;
  logic             w_acc;
  logic             w_acc_sel;
  logic             w_acc_last;
  logic [WIDTH-1:0] w_acc_data;

`ifdef STREAM_MUX2_RR_EN
  // Round-robin pointer: 0 = A preferred, 1 = B preferred on contention.
  logic r_ptr;

  assign w_prefer_b = r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (w_acc && w_acc_last) begin
      // Hand preference to the source that did not just finish a packet.
      r_ptr <= ~w_acc_sel;
    end
  end
`else
  assign w_prefer_b = 1'b0;
`endif

  // The single output stage can take a beat if it is empty or is being
  // drained this very cycle, which gives full-rate pass-through.
  assign w_slot_free = !r_valid || bus.out_ready;

  // Grant decode. In IDLE only a valid source can be granted; in a locked
  // state the owner keeps the grant even while it idles mid-packet, so the
  // other source cannot sneak a beat into the open packet.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.a_valid && bus.b_valid) begin
          w_grant_a = ~w_prefer_b;
          w_grant_b = w_prefer_b;
        end else begin
          w_grant_a = bus.a_valid;
          w_grant_b = bus.b_valid;
        end
      end
      ST_LOCKED_A: w_grant_a = 1'b1;
      ST_LOCKED_B: w_grant_b = 1'b1;
      default: begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
      end
    endcase
  end

  // Readies are held low during reset so nothing is accepted while the
  // block is being cleared.
  assign w_ready_a   = w_grant_a && w_slot_free && !i_rst;
  assign w_ready_b   = w_grant_b && w_slot_free && !i_rst;
  assign bus.a_ready = w_ready_a;
  assign bus.b_ready = w_ready_b;

  assign w_acc_a    = bus.a_valid && w_ready_a;
  assign w_acc_b    = bus.b_valid && w_ready_b;
  assign w_acc      = w_acc_a || w_acc_b;

  // At most one grant is active, so the accepted beat is selected by B's
  // acceptance alone. Data only feeds the output register.
  assign w_acc_sel  = w_acc_b;
  assign w_acc_last = w_acc_b ? bus.b_last : bus.a_last;
  assign w_acc_data = w_acc_b ? bus.b_data : bus.a_data;

  // Next-state: any accepted beat either closes the packet (back to IDLE)
  // or locks onto its source. Without an accepted beat the state holds,
  // so a stalled owner keeps the lock indefinitely.
  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      if (w_acc_last) begin
        w_state_nxt = ST_IDLE;
      end else if (w_acc_sel) begin
        w_state_nxt = ST_LOCKED_B;
      end else begin
        w_state_nxt = ST_LOCKED_A;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output stage. A consumed beat with no replacement only clears valid;
  // payload, sel and last keep their last values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_data  <= w_acc_data;
      r_sel   <= w_acc_sel;
      r_last  <= w_acc_last;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;
  assign bus.out_last  = r_last;
  assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux2.sv
// tb/tb_stream_mux2.sv - self-checking bench for stream_mux2
module tb_stream_mux2;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  stream_mux2_if #(.WIDTH(WIDTH)) bus ();

  stream_mux2 #(.WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Source queues hold pending beats as {last, data}; the head is what the
  // source presents, so data/last stay put until the beat is accepted.
  logic [WIDTH:0]   qa[$];
  logic [WIDTH:0]   qb[$];
  bit               en_a;
  bit               en_b;

  // Reference: the output stage is a one-deep FIFO of {sel, last, data}.
  // When empty, the output shows the last beat that left it.
  logic [WIDTH+1:0] oq[$];
  logic [WIDTH+1:0] held;
  int               owner;   // -1 none, 0 A, 1 B: source owning an open packet
  int               ptr;     // source preferred on contention

  int               n_vec;
  int               n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_beat(input int src, input logic [WIDTH-1:0] d, input bit l);
    if (src == 0) qa.push_back({l, d});
    else          qb.push_back({l, d});
  endtask

  task automatic push_rand_pkt(input int src);
    int len;
    len = $urandom_range(1, 4);
    for (int j = 0; j < len; j++) push_beat(src, WIDTH'($urandom), (j == len - 1));
  endtask

  // One clock cycle: drive at the falling edge, check just after, then
  // advance the reference on the rising edge.
  task automatic step(input bit r, input bit ordy);
    bit               va, vb, ga, gb, ra, rb, free, acc_a, acc_b;
    logic [WIDTH+1:0] cur;
    logic [WIDTH:0]   beat;
    @(negedge clk);
    rst = r;
    va = en_a && (qa.size() > 0);
    vb = en_b && (qb.size() > 0);
    bus.a_valid   = va;
    bus.a_data    = va ? qa[0][WIDTH-1:0] : WIDTH'($urandom);
    bus.a_last    = va ? qa[0][WIDTH]     : 1'($urandom);
    bus.b_valid   = vb;
    bus.b_data    = vb ? qb[0][WIDTH-1:0] : WIDTH'($urandom);
    bus.b_last    = vb ? qb[0][WIDTH]     : 1'($urandom);
    bus.out_ready = ordy;

    free = (oq.size() == 0) || ordy;
    ga = 0;
    gb = 0;
    if (owner == 0)      ga = 1;
    else if (owner == 1) gb = 1;
    else if (va && vb) begin
      if (ptr == 0) ga = 1;
      else          gb = 1;
    end
    else if (va) ga = 1;
    else if (vb) gb = 1;
    ra = ga && free && !r;
    rb = gb && free && !r;

    #1;
    cur = (oq.size() > 0) ? oq[0] : held;
    check_eq("out_valid", bus.out_valid, (oq.size() > 0));
    check_eq("out_data",  bus.out_data,  cur[WIDTH-1:0]);
    check_eq("out_last",  bus.out_last,  cur[WIDTH]);
    check_eq("out_sel",   bus.out_sel,   cur[WIDTH+1]);
    check_eq("a_ready",   bus.a_ready,   ra);
    check_eq("b_ready",   bus.b_ready,   rb);
    acc_a = va && ra;
    acc_b = vb && rb;

    @(posedge clk);
    if (r) begin
      oq.delete();
      held  = '0;
      owner = -1;
      ptr   = 0;
    end else begin
      if ((oq.size() > 0) && ordy) held = oq.pop_front();
      if (acc_a) begin
        beat = qa.pop_front();
        oq.push_back({1'b0, beat});
        owner = beat[WIDTH] ? -1 : 0;
        if (beat[WIDTH]) ptr = 1;
      end
      if (acc_b) begin
        beat = qb.pop_front();
        oq.push_back({1'b1, beat});
        owner = beat[WIDTH] ? -1 : 1;
        if (beat[WIDTH]) ptr = 0;
      end
`ifndef STREAM_MUX2_RR_EN
      ptr = 0;
`endif
    end
  endtask

  task automatic drain();
    en_a = 1;
    en_b = 1;
    for (int i = 0; i < 80; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && oq.size() == 0) break;
      step(0, 1);
    end
    check_eq("drain", qa.size() + qb.size() + oq.size(), 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    owner = -1;
    ptr   = 0;
    held  = '0;
    en_a  = 0;
    en_b  = 0;
    bus.a_valid = 0; bus.a_data = '0; bus.a_last = 0;
    bus.b_valid = 0; bus.b_data = '0; bus.b_last = 0;
    bus.out_ready = 1;

    // Reset with both sources valid; A wins right after release.
    en_a = 1;
    en_b = 1;
    push_beat(0, 8'h5A, 1);
    push_beat(1, 8'hC3, 1);
    step(1, 1);
    step(1, 1);
    drain();

    // Single source, three-beat packet.
    en_b = 0;
    push_beat(0, 8'h11, 0);
    push_beat(0, 8'h22, 0);
    push_beat(0, 8'h33, 1);
    for (int i = 0; i < 5; i++) step(0, 1);
    drain();

    // Lock hold: A opens a packet then idles while B waits.
    en_a = 1;
    en_b = 0;
    push_beat(0, 8'h01, 0);
    step(0, 1);
    en_a = 0;
    en_b = 1;
    push_beat(1, 8'hB5, 1);
    for (int i = 0; i < 3; i++) step(0, 1);
    push_beat(0, 8'h02, 1);
    drain();

    // Backpressure mid-stream.
    for (int k = 0; k < 3; k++) push_beat(0, 8'h40 + 8'(k), (k == 2));
    for (int k = 0; k < 2; k++) push_beat(1, 8'h50 + 8'(k), (k == 1));
    en_a = 1;
    en_b = 1;
    step(0, 1);
    step(0, 1);
    for (int i = 0; i < 4; i++) step(0, 0);
    drain();

    // Contention with two-beat packets on both sides.
    for (int k = 0; k < 3; k++) begin
      push_beat(0, 8'hA0, 0);
      push_beat(0, 8'hA1, 1);
      push_beat(1, 8'hB0, 0);
      push_beat(1, 8'hB1, 1);
    end
    drain();

    // Single-beat packets on both sides.
    for (int k = 0; k < 4; k++) begin
      push_beat(0, 8'h60 + 8'(k), 1);
      push_beat(1, 8'h70 + 8'(k), 1);
    end
    drain();

    // Randomized traffic with a mid-stream reset.
    for (int i = 0; i < 1500; i++) begin
      if (qa.size() < 2 && $urandom_range(0, 3) != 0) push_rand_pkt(0);
      if (qb.size() < 2 && $urandom_range(0, 3) != 0) push_rand_pkt(1);
      en_a = ($urandom_range(0, 9) < 7);
      en_b = ($urandom_range(0, 9) < 7);
      step((i == 700), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
